// File: rtl/rf_hazard_ctrl_pkg.sv
// rtl/rf_hazard_ctrl_pkg.sv - shared types and constants for the miniRV hazard/forwarding controller
package rf_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } slot_t;

    // x0 is hard-wired zero, so a slot targeting it never produces a usable value
    function automatic logic slot_writes(input slot_t s);
        return s.valid && s.we && (s.rd != '0);
    endfunction

endpackage

// File: rtl/rf_fwd_mux_sel.sv
// rtl/rf_fwd_mux_sel.sv - per-operand forwarding source select and load-use detection
module rf_fwd_mux_sel
    import rf_hazard_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_used,
    input  slot_t             i_ex,
    input  slot_t             i_mem,
    input  slot_t             i_wb,
    output logic [1:0]        o_sel,
    output logic              o_load_hit
);

    logic w_rs_live;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_rs_live = i_used && (i_rs != '0);
    assign w_ex_hit  = w_rs_live && slot_writes(i_ex)  && (i_ex.rd  == i_rs);
    assign w_mem_hit = w_rs_live && slot_writes(i_mem) && (i_mem.rd == i_rs);
    assign w_wb_hit  = w_rs_live && slot_writes(i_wb)  && (i_wb.rd  == i_rs);

    assign o_load_hit = w_ex_hit && i_ex.is_load;

    // A load in EX has no data yet; the stall covers it, so fall through to older slots
    always_comb begin
        o_sel = FWD_RF;
        if (w_ex_hit && !i_ex.is_load) begin
            o_sel = FWD_EX;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/rf_hazard_ctrl.sv
// rtl/rf_hazard_ctrl.sv - shadow pipeline of destinations, forwarding selects, load-use stall and flush/freeze
module rf_hazard_ctrl
    import rf_hazard_ctrl_pkg::*;
#(
    parameter int AW    = REG_AW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             freeze,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             stall,
    output logic             wb_we,
    output logic [AW-1:0]    wb_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    slot_t w_id_slot;
    logic  w_load_hit1;
    logic  w_load_hit2;
    logic  w_stall;
    logic  w_bubble;

    rf_fwd_mux_sel u_sel_rs1 (
        .i_rs       (id_rs1),
        .i_used     (id_valid && id_rs1_used),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (fwd1_sel),
        .o_load_hit (w_load_hit1)
    );

    rf_fwd_mux_sel u_sel_rs2 (
        .i_rs       (id_rs2),
        .i_used     (id_valid && id_rs2_used),
        .i_ex       (r_ex),
        .i_mem      (r_mem),
        .i_wb       (r_wb),
        .o_sel      (fwd2_sel),
        .o_load_hit (w_load_hit2)
    );

    // Flush kills the dependent instruction, so a load-use stall would be pointless
    assign w_stall  = id_valid && !flush && (w_load_hit1 || w_load_hit2);
    assign w_bubble = flush || w_stall || !id_valid;

    always_comb begin
        w_id_slot         = '0;
        w_id_slot.valid   = 1'b1;
        w_id_slot.rd      = id_rd;
        w_id_slot.we      = id_we;
        w_id_slot.is_load = id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
        end else if (!freeze) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= w_bubble ? slot_t'('0) : w_id_slot;
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall     = w_stall;
    assign wb_we     = slot_writes(r_wb);
    assign wb_rd     = r_wb.rd;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// tb/tb_rf_hazard_ctrl.sv - directed and randomized bench for rf_hazard_ctrl with an in-flight instruction model
module tb_rf_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        flush;
    logic        freeze;
    logic [1:0]  fwd1_sel;
    logic [1:0]  fwd2_sel;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model: in-flight instructions by age, 0 = just issued (EX), 2 = oldest (WB)
    logic        m_v  [3];
    logic [4:0]  m_rd [3];
    logic        m_we [3];
    logic        m_ld [3];
    logic [31:0] m_cnt;

    rf_hazard_ctrl #(.AW(5), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .freeze      (freeze),
        .fwd1_sel    (fwd1_sel),
        .fwd2_sel    (fwd2_sel),
        .stall       (stall),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic produces(input int age, input logic [4:0] rs);
        return m_v[age] && m_we[age] && (m_rd[age] != 5'd0) && (m_rd[age] == rs);
    endfunction

    // Youngest producer with data available wins; its age maps to the path number
    function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic used);
        if (!id_valid || !used || rs == 5'd0) return 2'd0;
        for (int age = 0; age < 3; age++) begin
            if (produces(age, rs) && !(age == 0 && m_ld[0])) return 2'(age + 1);
        end
        return 2'd0;
    endfunction

    function automatic logic m_stall();
        logic hit1, hit2;
        hit1 = id_rs1_used && produces(0, id_rs1) && m_ld[0];
        hit2 = id_rs2_used && produces(0, id_rs2) && m_ld[0];
        return id_valid && !flush && (hit1 || hit2);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            m_v[a] = 0; m_rd[a] = 0; m_we[a] = 0; m_ld[a] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic tick();
        logic st;
        st = m_stall();
        @(posedge clk);
        if (rst_n && !freeze) begin
            for (int a = 2; a > 0; a--) begin
                m_v[a] = m_v[a-1]; m_rd[a] = m_rd[a-1]; m_we[a] = m_we[a-1]; m_ld[a] = m_ld[a-1];
            end
            if (flush || st || !id_valid) begin
                m_v[0] = 0; m_rd[0] = 0; m_we[0] = 0; m_ld[0] = 0;
            end else begin
                m_v[0] = 1; m_rd[0] = id_rd; m_we[0] = id_we; m_ld[0] = id_is_load;
            end
            if (st) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_we = we; id_is_load = ld;
    endtask

    task automatic drain();
        flush = 0; freeze = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        set_id(1, 5, 1, 6, 1, 7, 1, 0);
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b expected 0", stall); end
        n_vec++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL reset_fwd1 got %0d expected 0", fwd1_sel); end
        n_vec++; if (fwd2_sel !== 2'd0) begin n_err++; $display("FAIL reset_fwd2 got %0d expected 0", fwd2_sel); end
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_wb_we got %0b expected 0", wb_we); end
        n_vec++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd got %0d expected 0", wb_rd); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d expected 0", stall_cnt); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        drain();
        set_id(1, 0, 0, 0, 0, 5, 1, 0);        // addi x5
        tick();
        set_id(1, 5, 1, 5, 1, 6, 1, 0);        // add x6,x5,x5
        #1;
        n_vec++; if (fwd1_sel !== 2'd1) begin n_err++; $display("FAIL b2b_fwd1_ex got %0d expected 1", fwd1_sel); end
        n_vec++; if (fwd2_sel !== 2'd1) begin n_err++; $display("FAIL b2b_fwd2_ex got %0d expected 1", fwd2_sel); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall got %0b expected 0", stall); end
        tick();
        set_id(1, 5, 1, 0, 0, 0, 0, 0);
        #1;
        n_vec++; if (fwd1_sel !== 2'd2) begin n_err++; $display("FAIL b2b_fwd1_mem got %0d expected 2", fwd1_sel); end
        tick();
        #1;
        n_vec++; if (fwd1_sel !== 2'd3) begin n_err++; $display("FAIL b2b_fwd1_wb got %0d expected 3", fwd1_sel); end
        n_vec++; if (wb_we !== 1'b1 || wb_rd !== 5'd5) begin
            n_err++; $display("FAIL b2b_wb got we=%0b rd=%0d expected we=1 rd=5", wb_we, wb_rd);
        end
        tick();
        #1;
        n_vec++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL b2b_fwd1_rf got %0d expected 0", fwd1_sel); end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        drain();
        c0 = m_cnt;
        set_id(1, 1, 1, 0, 0, 7, 1, 1);        // lw x7
        tick();
        set_id(1, 7, 1, 0, 1, 8, 1, 0);        // add x8,x7,x0
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got %0b expected 1", stall); end
        n_vec++; if (fwd2_sel !== 2'd0) begin n_err++; $display("FAIL lu_x0_fwd2 got %0d expected 0", fwd2_sel); end
        tick();
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_stall_once got %0b expected 0", stall); end
        n_vec++; if (fwd1_sel !== 2'd2) begin n_err++; $display("FAIL lu_fwd1_mem got %0d expected 2", fwd1_sel); end
        n_vec++; if (stall_cnt !== c0 + 32'd1) begin n_err++; $display("FAIL lu_cnt got %0d expected %0d", stall_cnt, c0 + 1); end
        tick();
        set_id(1, 8, 1, 7, 1, 0, 0, 0);
        #1;
        // the bubble sits in MEM, so x7 is now only in WB
        n_vec++; if (fwd1_sel !== 2'd1 || fwd2_sel !== 2'd3) begin
            n_err++; $display("FAIL lu_after got fwd1=%0d fwd2=%0d expected 1 3", fwd1_sel, fwd2_sel);
        end
    endtask

    task automatic test_x0();
        drain();
        set_id(1, 0, 0, 0, 0, 0, 1, 1);        // lw x0
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        n_vec++; if (stall !== 1'b0 || fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
            n_err++; $display("FAIL x0_read got stall=%0b fwd1=%0d fwd2=%0d expected 0 0 0", stall, fwd1_sel, fwd2_sel);
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL x0_wb_we got %0b expected 0", wb_we); end
    endtask

    task automatic test_flush_load_use();
        logic [31:0] c0;
        drain();
        c0 = m_cnt;
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 1, 0, 0, 8, 1, 0);
        flush = 1;
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %0b expected 0", stall); end
        tick();
        flush = 0;
        set_id(1, 8, 1, 7, 1, 0, 0, 0);
        #1;
        n_vec++; if (fwd1_sel !== 2'd0) begin n_err++; $display("FAIL flush_bubble got %0d expected 0", fwd1_sel); end
        n_vec++; if (fwd2_sel !== 2'd2) begin n_err++; $display("FAIL flush_fwd2 got %0d expected 2", fwd2_sel); end
        n_vec++; if (stall_cnt !== c0) begin n_err++; $display("FAIL flush_cnt got %0d expected %0d", stall_cnt, c0); end
    endtask

    task automatic test_freeze();
        logic [31:0] c0;
        drain();
        c0 = m_cnt;
        set_id(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        set_id(1, 7, 1, 0, 0, 8, 1, 0);
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL frz_stall_%0d got %0b expected 1", i, stall); end
            tick();
        end
        n_vec++; if (stall_cnt !== c0) begin n_err++; $display("FAIL frz_cnt got %0d expected %0d", stall_cnt, c0); end
        freeze = 0;
        #1;
        n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL frz_release got %0b expected 1", stall); end
        tick();
        #1;
        n_vec++; if (stall_cnt !== c0 + 32'd1) begin n_err++; $display("FAIL frz_cnt_post got %0d expected %0d", stall_cnt, c0 + 1); end
        n_vec++; if (stall !== 1'b0 || fwd1_sel !== 2'd2) begin
            n_err++; $display("FAIL frz_fwd got stall=%0b fwd1=%0d expected 0 2", stall, fwd1_sel);
        end
    endtask

    task automatic test_async_reset();
        drain();
        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        n_vec++; if (wb_we !== 1'b1 || wb_rd !== 5'd9) begin
            n_err++; $display("FAIL ar_pre got we=%0b rd=%0d expected 1 9", wb_we, wb_rd);
        end
        #1;
        rst_n = 0;
        model_reset();
        #1;
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL ar_wb_we got %0b expected 0", wb_we); end
        n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL ar_cnt got %0d expected 0", stall_cnt); end
        #4;
        rst_n = 1;
        set_id(1, 9, 1, 9, 1, 0, 0, 0);
        #1;
        n_vec++; if (fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
            n_err++; $display("FAIL ar_x9 got fwd1=%0d fwd2=%0d expected 0 0", fwd1_sel, fwd2_sel);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0] e1, e2;
        for (int i = 0; i < 400; i++) begin
            set_id(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 6)), 1'($urandom),
                   5'($urandom_range(0, 6)), 1'($urandom), 5'($urandom_range(0, 6)),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            flush  = ($urandom_range(0, 7) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            #1;
            e1 = m_sel(id_rs1, id_rs1_used);
            e2 = m_sel(id_rs2, id_rs2_used);
            n_vec++; if (fwd1_sel !== e1) begin n_err++; $display("FAIL rnd%0d_fwd1 got %0d expected %0d", i, fwd1_sel, e1); end
            n_vec++; if (fwd2_sel !== e2) begin n_err++; $display("FAIL rnd%0d_fwd2 got %0d expected %0d", i, fwd2_sel, e2); end
            n_vec++; if (stall !== m_stall()) begin n_err++; $display("FAIL rnd%0d_stall got %0b expected %0b", i, stall, m_stall()); end
            n_vec++; if (wb_we !== (m_v[2] && m_we[2] && m_rd[2] != 0)) begin
                n_err++; $display("FAIL rnd%0d_wb_we got %0b", i, wb_we);
            end
            n_vec++; if (wb_rd !== m_rd[2]) begin n_err++; $display("FAIL rnd%0d_wb_rd got %0d expected %0d", i, wb_rd, m_rd[2]); end
            n_vec++; if (stall_cnt !== m_cnt) begin n_err++; $display("FAIL rnd%0d_cnt got %0d expected %0d", i, stall_cnt, m_cnt); end
            tick();
        end
        flush = 0; freeze = 0;
    endtask

    initial begin
        rst_n = 0; flush = 0; freeze = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_x0();
        test_flush_load_use();
        test_freeze();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
